// File: rtl/relay_pulse_controller.sv
// rtl/relay_pulse_controller.sv - latching relay coil pulse sequencer with power-up reset sweep
// One command at a time: energize one coil for PULSE_CYCLES, then hold off for SETTLE_CYCLES.
module relay_pulse_controller #(
  parameter int PULSE_CYCLES  = 2500000,
  parameter int SETTLE_CYCLES = 250000,
  parameter int NUM_RELAYS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_channel,
  input  logic                  cmd_dir,
  output logic [NUM_RELAYS-1:0] coil_set,
  output logic [NUM_RELAYS-1:0] coil_reset,
  output logic [NUM_RELAYS-1:0] relay_state,
  output logic                  busy,
  output logic                  cmd_err
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    INIT_PULSE,
    INIT_SETTLE,
    IDLE,
    PULSE,
    SETTLE
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         count, count_next;
  logic [3:0]            init_idx, init_idx_next;
  logic [2:0]            ch_q;
  logic                  dir_q;
  logic [NUM_RELAYS-1:0] coil_set_next, coil_reset_next, relay_state_next;
  logic                  cmd_err_next;
  logic                  accept;
  logic                  ch_ok;

  function automatic logic [NUM_RELAYS-1:0] onehot(input logic [2:0] idx);
    return NUM_RELAYS'(1) << idx;
  endfunction

  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE) || rst;
  assign accept    = cmd_valid && cmd_ready;
  assign ch_ok     = ({1'b0, cmd_channel} < 4'(NUM_RELAYS));

  // Reset parks in INIT_SETTLE with an expired counter so the sweep starts on the first free edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT_SETTLE;
      count       <= '0;
      init_idx    <= '0;
      coil_set    <= '0;
      coil_reset  <= '0;
      relay_state <= '0;
      cmd_err     <= 1'b0;
      ch_q        <= '0;
      dir_q       <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      init_idx    <= init_idx_next;
      coil_set    <= coil_set_next;
      coil_reset  <= coil_reset_next;
      relay_state <= relay_state_next;
      cmd_err     <= cmd_err_next;
      if (accept) begin
        ch_q  <= cmd_channel;
        dir_q <= cmd_dir;
      end
    end
  end

  always_comb begin
    state_next       = state;
    count_next       = count;
    init_idx_next    = init_idx;
    coil_set_next    = coil_set;
    coil_reset_next  = coil_reset;
    relay_state_next = relay_state;
    cmd_err_next     = 1'b0;
    case (state)
      INIT_SETTLE: begin
        if (count == '0) begin
          if (init_idx == 4'(NUM_RELAYS)) begin
            state_next = IDLE;
          end else begin
            state_next      = INIT_PULSE;
            count_next      = PULSE_LOAD;
            coil_reset_next = onehot(init_idx[2:0]);
          end
        end else begin
          count_next = count - 1'b1;
        end
      end
      INIT_PULSE: begin
        if (count == '0) begin
          state_next      = INIT_SETTLE;
          count_next      = SETTLE_LOAD;
          coil_reset_next = '0;
          init_idx_next   = init_idx + 4'd1;
        end else begin
          count_next = count - 1'b1;
        end
      end
      IDLE: begin
        if (accept) begin
          if (ch_ok) begin
            state_next      = PULSE;
            count_next      = PULSE_LOAD;
            coil_set_next   = cmd_dir ? onehot(cmd_channel) : '0;
            coil_reset_next = cmd_dir ? '0 : onehot(cmd_channel);
          end else begin
            cmd_err_next = 1'b1;
          end
        end
      end
      PULSE: begin
        if (count == '0) begin
          state_next       = SETTLE;
          count_next       = SETTLE_LOAD;
          coil_set_next    = '0;
          coil_reset_next  = '0;
          relay_state_next = dir_q ? (relay_state | onehot(ch_q)) : (relay_state & ~onehot(ch_q));
        end else begin
          count_next = count - 1'b1;
        end
      end
      SETTLE: begin
        if (count == '0) begin
          state_next = IDLE;
        end else begin
          count_next = count - 1'b1;
        end
      end
      default: begin
        state_next      = INIT_SETTLE;
        count_next      = '0;
        init_idx_next   = '0;
        coil_set_next   = '0;
        coil_reset_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_relay_pulse_controller.sv
// tb/tb_relay_pulse_controller.sv - directed bench for relay_pulse_controller (8/4/4 configuration)
module tb_relay_pulse_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_channel;
  logic       cmd_dir;
  logic [3:0] coil_set;
  logic [3:0] coil_reset;
  logic [3:0] relay_state;
  logic       busy;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  relay_pulse_controller #(
    .PULSE_CYCLES (8),
    .SETTLE_CYCLES(4),
    .NUM_RELAYS   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_channel(cmd_channel),
    .cmd_dir    (cmd_dir),
    .coil_set   (coil_set),
    .coil_reset (coil_reset),
    .relay_state(relay_state),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (((coil_set & coil_reset) == 4'b0) && ($countones(coil_set | coil_reset) <= 1))
    else begin
      errors++;
      $display("FAIL coil_invariant: coil_set=%b coil_reset=%b", coil_set, coil_reset);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0] ch;
    logic       dir;
    logic [3:0] exp_set;
    logic [3:0] exp_reset;
    logic [3:0] exp_state;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Entered just after rst drops; the first edge below is the first one that sees rst low.
  task automatic check_init;
    int total;
    int len;
    int gap;
    int bad;
    logic [3:0] exp;
    total = 0;
    tick;
    for (int k = 0; k < 4; k++) begin
      exp = 4'(1 << k);
      check("init_coil_first", coil_reset, exp);
      len = 0;
      bad = 0;
      while (coil_reset != 4'b0 && len < 40) begin
        if (coil_reset !== exp || coil_set !== 4'b0) bad++;
        len++;
        tick;
        total++;
      end
      check("init_pulse_len", len, 8);
      check("init_coil_stable", bad, 0);
      gap = 0;
      while ((coil_reset | coil_set) == 4'b0 && !cmd_ready && gap < 40) begin
        gap++;
        tick;
        total++;
      end
      check("init_gap", gap, 4);
    end
    check("init_ready_latency", total, 48);
    check("init_ready", cmd_ready, 1);
    check("init_busy", busy, 0);
    check("init_relay_state", relay_state, 4'b0000);
  endtask

  task automatic run_cmd(input vec_t v);
    int len;
    int total;
    int bad;
    check("pre_ready", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_channel = v.ch;
    cmd_dir     = v.dir;
    tick;
    total = 1;
    cmd_valid   = 1'b0;
    cmd_channel = v.ch ^ 3'b011;
    cmd_dir     = ~v.dir;
    check("cmd_err", cmd_err, v.exp_err);
    check("busy_after_accept", busy, !v.exp_err);
    check("coil_set_first", coil_set, v.exp_set);
    check("coil_reset_first", coil_reset, v.exp_reset);
    len = 0;
    bad = 0;
    while ((coil_set | coil_reset) != 4'b0 && len < 40) begin
      if (coil_set !== v.exp_set || coil_reset !== v.exp_reset) bad++;
      len++;
      tick;
      total++;
    end
    check("pulse_len", len, v.exp_err ? 0 : 8);
    check("coil_stable", bad, 0);
    check("relay_state", relay_state, v.exp_state);
    while (!cmd_ready && total < 40) begin
      tick;
      total++;
    end
    check("ready_latency", total, v.exp_err ? 1 : 13);
    tick;
    check("err_cleared", cmd_err, 0);
  endtask

  initial begin
    int acc[3];
    int n_acc;
    int set_cnt;
    int bad;
    int wait_cnt;

    vecs[0] = '{3'd2, 1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0};
    vecs[1] = '{3'd2, 1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0};
    vecs[2] = '{3'd0, 1'b1, 4'b0001, 4'b0000, 4'b0101, 1'b0};
    vecs[3] = '{3'd2, 1'b0, 4'b0000, 4'b0100, 4'b0001, 1'b0};
    vecs[4] = '{3'd3, 1'b1, 4'b1000, 4'b0000, 4'b1001, 1'b0};
    vecs[5] = '{3'd5, 1'b1, 4'b0000, 4'b0000, 4'b1001, 1'b1};
    vecs[6] = '{3'd4, 1'b0, 4'b0000, 4'b0000, 4'b1001, 1'b1};
    vecs[7] = '{3'd7, 1'b1, 4'b0000, 4'b0000, 4'b1001, 1'b1};
    vecs[8] = '{3'd0, 1'b0, 4'b0000, 4'b0001, 4'b1000, 1'b0};
    vecs[9] = '{3'd3, 1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b0};

    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_channel = 3'd0;
    cmd_dir     = 1'b0;
    repeat (3) tick;
    check("rst_coil_set", coil_set, 4'b0000);
    check("rst_coil_reset", coil_reset, 4'b0000);
    check("rst_relay_state", relay_state, 4'b0000);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_cmd_err", cmd_err, 0);
    rst = 1'b0;
    check_init();

    for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

    // cmd_valid held across busy periods: one accept per 13 cycles.
    cmd_valid   = 1'b1;
    cmd_channel = 3'd1;
    cmd_dir     = 1'b1;
    n_acc   = 0;
    set_cnt = 0;
    bad     = 0;
    for (int i = 0; i < 80 && n_acc < 3; i++) begin
      if (cmd_ready) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      tick;
      if (coil_set == 4'b0010) set_cnt++;
      else if ((coil_set | coil_reset) != 4'b0) bad++;
    end
    cmd_valid = 1'b0;
    wait_cnt = 0;
    while (!cmd_ready && wait_cnt < 40) begin
      tick;
      wait_cnt++;
      if (coil_set == 4'b0010) set_cnt++;
      else if ((coil_set | coil_reset) != 4'b0) bad++;
    end
    check("held_accepts", n_acc, 3);
    check("held_spacing_1", acc[1] - acc[0], 13);
    check("held_spacing_2", acc[2] - acc[1], 13);
    check("held_set_cycles", set_cnt, 24);
    check("held_other_coils", bad, 0);
    check("held_relay_state", relay_state, 4'b0010);
    check("held_ready", cmd_ready, 1);

    // Reset lands in the third cycle of a set pulse on relay 0.
    cmd_valid   = 1'b1;
    cmd_channel = 3'd0;
    cmd_dir     = 1'b1;
    tick;
    cmd_valid = 1'b0;
    check("mid_coil_c1", coil_set, 4'b0001);
    tick;
    tick;
    check("mid_coil_c3", coil_set, 4'b0001);
    rst = 1'b1;
    tick;
    check("mid_rst_coil_set", coil_set, 4'b0000);
    check("mid_rst_coil_reset", coil_reset, 4'b0000);
    check("mid_rst_relay_state", relay_state, 4'b0000);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_ready", cmd_ready, 0);
    tick;
    rst = 1'b0;
    check_init();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/relay_pulse_controller.md
RELAY_PULSE_CONTROLLER -- requirements
Module: relay_pulse_controller

Interface
REQ-001 Parameter PULSE_CYCLES, default 2500000, coil energize time in clk cycles (10 ms at 250 MHz); legal range 1..2^24-1.
REQ-002 Parameter SETTLE_CYCLES, default 250000, dead time after each pulse before next command (1 ms at 250 MHz); legal range 1..2^24-1.
REQ-003 Parameter NUM_RELAYS, default 4, number of latching relay channels; legal range 1..8.
REQ-004 clk  input  1  single clock for all logic (sys_clk domain, 250 MHz).
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 cmd_valid  input  1  command request from APB relay register.
REQ-007 cmd_ready  output  1  block accepts command this cycle.
REQ-008 cmd_channel  input  3  target relay index.
REQ-009 cmd_dir  input  1  1 = set (route to secondary path), 0 = reset (primary path).
REQ-010 coil_set  output  NUM_RELAYS  set-coil drive, one-hot or zero.
REQ-011 coil_reset  output  NUM_RELAYS  reset-coil drive, one-hot or zero.
REQ-012 relay_state  output  NUM_RELAYS  commanded latched state per relay (1 = set), fed to LED gating logic.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 cmd_err  output  1  one-cycle pulse when an accepted command had cmd_channel >= NUM_RELAYS.

Function
REQ-015 States: INIT_PULSE, INIT_SETTLE, IDLE, PULSE, SETTLE; single down-counter of width $clog2(max(PULSE_CYCLES,SETTLE_CYCLES)+1) shared by all states.
REQ-016 Handshake: command accepted on cycle where cmd_valid && cmd_ready; cmd_ready = 1 only in IDLE and not in rst.
REQ-017 cmd_channel, cmd_dir captured into registers on accept; inputs may change afterward without effect.
REQ-018 Accept with valid channel: next cycle state = PULSE, counter = PULSE_CYCLES-1, coil_set[ch] (dir=1) or coil_reset[ch] (dir=0) asserted.
REQ-019 Coil outputs registered; exactly PULSE_CYCLES consecutive cycles of coil assertion per pulse.
REQ-020 PULSE with counter == 0: coils deassert next cycle, state = SETTLE, counter = SETTLE_CYCLES-1.
REQ-021 SETTLE with counter == 0: state = IDLE next cycle; cmd_ready high that cycle.
REQ-022 Minimum spacing between accepts: PULSE_CYCLES + SETTLE_CYCLES + 1 cycles.
REQ-023 relay_state[ch] updates to cmd_dir on the same cycle the pulse ends (first SETTLE cycle), not at accept.
REQ-024 Commands always pulse, even if relay_state[ch] already equals cmd_dir (physical state not trusted).
REQ-025 Invalid channel (>= NUM_RELAYS): command consumed, cmd_err pulses one cycle after accept, no coil asserted, state stays IDLE, relay_state unchanged.
REQ-026 Invariant: coil_set & coil_reset == 0 and popcount(coil_set | coil_reset) <= 1 on every cycle.
REQ-027 No command queuing; cmd_valid held while busy is simply not accepted until IDLE.

Reset
REQ-028 During rst: coil_set = 0, coil_reset = 0, relay_state = 0, cmd_ready = 0, busy = 1, cmd_err = 0, counter cleared.
REQ-029 After rst deasserts, block autonomously pulses coil_reset[0..NUM_RELAYS-1] in ascending order, each PULSE_CYCLES followed by SETTLE_CYCLES (INIT_PULSE/INIT_SETTLE), then enters IDLE.
REQ-030 rst asserted mid-pulse: coils drop on the next clk edge and the init sequence restarts from relay 0 after release.

Verification (bench uses PULSE_CYCLES=8, SETTLE_CYCLES=4, NUM_RELAYS=4)
REQ-031 Release rst -> coil_reset = 0001,0010,0100,1000 each 8 cycles with 4-cycle gaps; cmd_ready rises 48 cycles after release; relay_state = 0000.
REQ-032 From IDLE, cmd ch=2 dir=1 -> coil_set = 0100 for exactly 8 cycles; relay_state = 0100 on first SETTLE cycle; cmd_ready high 13 cycles after accept.
REQ-033 cmd_valid held high continuously with ch=1 dir=1 -> accepts every 13 cycles; coil_set = 0010 each time; relay_state stays 0010.
REQ-034 cmd ch=5 -> cmd_err high one cycle, no coil activity, cmd_ready high next cycle.
REQ-035 rst asserted on cycle 3 of a set pulse on ch=0 -> coil_set = 0000 next cycle, relay_state = 0000, full 4-relay init replays after release.
REQ-036 All scenarios: assertion checks REQ-026 invariant every cycle.
